// File: rtl/frame_fill_engine_if.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | frame_fill_engine_if: control and pixel-write bus of the fill engine
// | Rev 1.0 - initial release                                         |
// +-------------------------------------------------------------------+
interface frame_fill_engine_if #(
   parameter int COORD_W = 10,
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 19
) ();
   logic               fill_start;
   logic               full_mode;
   logic [COORD_W-1:0] rect_x0;
   logic [COORD_W-1:0] rect_y0;
   logic [COORD_W-1:0] rect_x1;
   logic [COORD_W-1:0] rect_y1;
   logic [DATA_W-1:0]  fill_value;
   logic               fill_abort;
   logic               wr_ready;
   logic               wr_en;
   logic [ADDR_W-1:0]  wr_addr;
   logic [DATA_W-1:0]  wr_data;
   logic [COORD_W-1:0] DrawX;
   logic [COORD_W-1:0] DrawY;
   logic               fill_busy;
   logic               fill_done;

   modport master (
      input  fill_start, full_mode, rect_x0, rect_y0, rect_x1, rect_y1,
             fill_value, fill_abort, wr_ready,
      output wr_en, wr_addr, wr_data, DrawX, DrawY, fill_busy, fill_done
   );

   modport slave (
      output fill_start, full_mode, rect_x0, rect_y0, rect_x1, rect_y1,
             fill_value, fill_abort, wr_ready,
      input  wr_en, wr_addr, wr_data, DrawX, DrawY, fill_busy, fill_done
   );
endinterface
`default_nettype wire

// File: rtl/frame_fill_engine.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | frame_fill_engine: raster fill of full frame or clipped rectangle |
// | Rev 1.0 - initial release                                         |
// +-------------------------------------------------------------------+
module frame_fill_engine #(
   parameter int H_RES   = 640,
   parameter int V_RES   = 480,
   parameter int COORD_W = 10,
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 19
) (
   input  wire logic            Clk,
   input  wire logic            Reset,
   frame_fill_engine_if.master  bus
);
   localparam logic [COORD_W-1:0] c_x_max = COORD_W'(H_RES - 1);
   localparam logic [COORD_W-1:0] c_y_max = COORD_W'(V_RES - 1);
   localparam logic [ADDR_W-1:0]  c_h_res = ADDR_W'(H_RES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               armed_q, armed_d;
   logic [COORD_W-1:0] x0_q, x0_d, x1_q, x1_d, y1_q, y1_d;
   logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic               wr_en_q, wr_en_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [COORD_W-1:0] w_sx0, w_sy0, w_sx1, w_sy1;
   logic               w_empty;
   logic [ADDR_W-1:0]  w_start_addr;
   logic [ADDR_W-1:0]  w_row_step;

   // Region requested at start, with the far corner clipped to the frame
   always_comb begin
      if (bus.full_mode) begin
         w_sx0 = '0;
         w_sy0 = '0;
         w_sx1 = c_x_max;
         w_sy1 = c_y_max;
      end else begin
         w_sx0 = bus.rect_x0;
         w_sy0 = bus.rect_y0;
         w_sx1 = (bus.rect_x1 > c_x_max) ? c_x_max : bus.rect_x1;
         w_sy1 = (bus.rect_y1 > c_y_max) ? c_y_max : bus.rect_y1;
      end
   end

   assign w_empty      = (w_sx0 > w_sx1) || (w_sy0 > w_sy1);
   // Constant-coefficient product, evaluated only once per fill at start
   assign w_start_addr = ADDR_W'(w_sy0) * c_h_res + ADDR_W'(w_sx0);
   assign w_row_step   = c_h_res - ADDR_W'(x1_q - x0_q);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_IDLE;
         armed_q <= 1'b1;
         x0_q    <= '0;
         x1_q    <= '0;
         y1_q    <= '0;
         x_q     <= '0;
         y_q     <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         wr_en_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         armed_q <= armed_d;
         x0_q    <= x0_d;
         x1_q    <= x1_d;
         y1_q    <= y1_d;
         x_q     <= x_d;
         y_q     <= y_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         wr_en_q <= wr_en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      armed_d = armed_q | ~bus.fill_start;
      x0_d    = x0_q;
      x1_d    = x1_q;
      y1_d    = y1_q;
      x_d     = x_q;
      y_d     = y_q;
      addr_d  = addr_q;
      data_d  = data_q;
      wr_en_d = wr_en_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            wr_en_d = 1'b0;
            busy_d  = 1'b0;
            if (bus.fill_start && armed_q) begin
               armed_d = 1'b0;
               x0_d    = w_sx0;
               x1_d    = w_sx1;
               y1_d    = w_sy1;
               data_d  = bus.fill_value;
               if (w_empty) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_RUN;
                  x_d     = w_sx0;
                  y_d     = w_sy0;
                  addr_d  = w_start_addr;
                  wr_en_d = 1'b1;
                  busy_d  = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (bus.fill_abort) begin
               state_d = S_IDLE;
               wr_en_d = 1'b0;
               busy_d  = 1'b0;
            end else if (bus.wr_ready) begin
               if (x_q != x1_q) begin
                  x_d    = x_q + 1'b1;
                  addr_d = addr_q + 1'b1;
               end else if (y_q != y1_q) begin
                  x_d    = x0_q;
                  y_d    = y_q + 1'b1;
                  addr_d = addr_q + w_row_step;
               end else begin
                  state_d = S_DONE;
                  wr_en_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            wr_en_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign bus.wr_en     = wr_en_q;
   assign bus.wr_addr   = addr_q;
   assign bus.wr_data   = data_q;
   assign bus.DrawX     = x_q;
   assign bus.DrawY     = y_q;
   assign bus.fill_busy = busy_q;
   assign bus.fill_done = done_q;
endmodule
`default_nettype wire

// File: tb/tb_frame_fill_engine.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_frame_fill_engine: randomized fills checked against pixel lists|
// | Rev 1.0 - initial release                                         |
// +-------------------------------------------------------------------+
module tb_frame_fill_engine;
   localparam int H  = 8;
   localparam int V  = 4;
   localparam int CW = 6;
   localparam int DW = 16;
   localparam int AW = 5;

   logic Clk = 1'b0;
   logic Reset;
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 Clk = ~Clk;

   frame_fill_engine_if #(.COORD_W(CW), .DATA_W(DW), .ADDR_W(AW)) ff ();

   frame_fill_engine #(
      .H_RES(H), .V_RES(V), .COORD_W(CW), .DATA_W(DW), .ADDR_W(AW)
   ) u_dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (ff)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_wr_en"}, 32'(ff.wr_en), 0);
      chk({tag, "_busy"},  32'(ff.fill_busy), 0);
      chk({tag, "_done"},  32'(ff.fill_done), 0);
   endtask

   // Called at a negedge; returns at a negedge with the engine idle.
   // rmode: 0 ready always, 1 ready pattern 1,0,0, 2 random ready.
   task automatic do_fill(input bit full, input int rx0, input int ry0,
                          input int rx1, input int ry1, input logic [15:0] val,
                          input int rmode, input int abort_at, input bit hold);
      int ex0, ey0, ex1, ey1;
      int qx[$];
      int qy[$];
      int acc = 0;
      int cyc = 0;
      int ph  = 0;
      bit fin = 0;
      bit rdy;
      logic [CW-1:0] t;

      ex0 = full ? 0 : rx0;
      ey0 = full ? 0 : ry0;
      ex1 = full ? H - 1 : ((rx1 > H - 1) ? H - 1 : rx1);
      ey1 = full ? V - 1 : ((ry1 > V - 1) ? V - 1 : ry1);
      for (int y = ey0; y <= ey1; y++)
         for (int x = ex0; x <= ex1; x++) begin
            qx.push_back(x);
            qy.push_back(y);
         end

      ff.full_mode  = full;
      t = rx0[CW-1:0]; ff.rect_x0 = t;
      t = ry0[CW-1:0]; ff.rect_y0 = t;
      t = rx1[CW-1:0]; ff.rect_x1 = t;
      t = ry1[CW-1:0]; ff.rect_y1 = t;
      ff.fill_value = val;
      ff.fill_abort = 1'b0;
      ff.wr_ready   = 1'b0;
      ff.fill_start = 1'b1;
      @(negedge Clk);
      if (!hold) ff.fill_start = 1'b0;
      // Inputs are scrambled to prove the engine ignores them once running
      ff.rect_x0 = '1;
      ff.fill_value = ~val;

      if (qx.size() == 0) begin
         chk("empty_wr_en", 32'(ff.wr_en), 0);
         chk("empty_done",  32'(ff.fill_done), 1);
         chk("empty_busy",  32'(ff.fill_busy), 0);
         @(negedge Clk);
         chk_quiet("empty_after");
         return;
      end

      while (!fin) begin
         if (qx.size() == 0) begin
            chk("end_wr_en", 32'(ff.wr_en), 0);
            chk("end_busy",  32'(ff.fill_busy), 0);
            chk("done_pulse", 32'(ff.fill_done), 1);
            @(negedge Clk);
            chk_quiet("done_after");
            fin = 1;
         end else begin
            chk("run_wr_en", 32'(ff.wr_en), 1);
            chk("run_busy",  32'(ff.fill_busy), 1);
            chk("run_done",  32'(ff.fill_done), 0);
            chk("DrawX",     32'(ff.DrawX), 32'(qx[0]));
            chk("DrawY",     32'(ff.DrawY), 32'(qy[0]));
            chk("wr_addr",   32'(ff.wr_addr), 32'(qy[0] * H + qx[0]));
            chk("wr_data",   32'(ff.wr_data), 32'(val));
            case (rmode)
               0:       rdy = 1'b1;
               1:       rdy = (ph % 3) == 0;
               default: rdy = 1'($urandom_range(0, 1));
            endcase
            ph++;
            ff.wr_ready   = rdy;
            ff.fill_abort = (acc == abort_at);
            @(negedge Clk);
            if (rdy) begin
               void'(qx.pop_front());
               void'(qy.pop_front());
               acc++;
            end
            if (ff.fill_abort) begin
               ff.fill_abort = 1'b0;
               chk_quiet("abort");
               @(negedge Clk);
               chk_quiet("abort_after");
               fin = 1;
            end
         end
         cyc++;
         if (cyc > 2000 && !fin) begin
            chk("timeout", 1, 0);
            fin = 1;
         end
      end
      ff.wr_ready = 1'b0;
   endtask

   initial begin
      Reset         = 1'b1;
      ff.fill_start = 1'b0;
      ff.full_mode  = 1'b0;
      ff.rect_x0    = '0;
      ff.rect_y0    = '0;
      ff.rect_x1    = '0;
      ff.rect_y1    = '0;
      ff.fill_value = '0;
      ff.fill_abort = 1'b0;
      ff.wr_ready   = 1'b0;
      repeat (3) @(negedge Clk);
      chk_quiet("reset");
      chk("reset_X",    32'(ff.DrawX), 0);
      chk("reset_Y",    32'(ff.DrawY), 0);
      chk("reset_addr", 32'(ff.wr_addr), 0);
      chk("reset_data", 32'(ff.wr_data), 0);
      Reset = 1'b0;
      @(negedge Clk);

      do_fill(1, 0, 0, 0, 0, 16'h1234, 0, -1, 0);   // full frame, no stalls
      do_fill(0, 2, 1, 4, 2, 16'hBEEF, 0, -1, 0);   // small rectangle
      do_fill(0, 2, 1, 4, 2, 16'hBEEF, 1, -1, 0);   // same, with stalls
      do_fill(0, 5, 0, 3, 2, 16'h5555, 0, -1, 0);   // x0 > x1
      do_fill(0, 5, 0, 20, 1, 16'hA0A0, 0, -1, 0);  // x1 clipped to 7
      do_fill(0, 9, 0, 20, 3, 16'h0F0F, 0, -1, 0);  // x0 beyond frame
      do_fill(0, 0, 2, 1, 30, 16'hC3C3, 2, -1, 0);  // y1 clipped to 3

      // Held start gives one fill only, re-arms after one low cycle
      do_fill(1, 0, 0, 0, 0, 16'h7777, 0, -1, 1);
      for (int i = 0; i < 100; i++) begin
         @(negedge Clk);
         if (i % 10 == 0) chk_quiet("held_start");
      end
      ff.fill_start = 1'b0;
      @(negedge Clk);
      do_fill(1, 0, 0, 0, 0, 16'h8888, 0, -1, 0);

      do_fill(1, 0, 0, 0, 0, 16'h1111, 0, 5, 0);    // abort after 5 accepts

      // Reset in the middle of a fill
      ff.full_mode  = 1'b1;
      ff.fill_value = 16'hDEAD;
      ff.wr_ready   = 1'b1;
      ff.fill_start = 1'b1;
      @(negedge Clk);
      ff.fill_start = 1'b0;
      repeat (6) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      chk_quiet("midreset");
      chk("midreset_X",    32'(ff.DrawX), 0);
      chk("midreset_Y",    32'(ff.DrawY), 0);
      chk("midreset_addr", 32'(ff.wr_addr), 0);
      chk("midreset_data", 32'(ff.wr_data), 0);
      Reset         = 1'b0;
      ff.wr_ready   = 1'b0;
      @(negedge Clk);
      do_fill(0, 1, 1, 6, 3, 16'h4242, 0, -1, 0);

      for (int n = 0; n < 30; n++) begin
         do_fill($urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 10)), int'($urandom_range(0, 5)),
                 int'($urandom_range(0, 12)), int'($urandom_range(0, 6)),
                 16'($urandom), int'($urandom_range(0, 2)),
                 ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 6)) : -1, 0);
         repeat ($urandom_range(0, 2)) @(negedge Clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
